// File: rtl/imem_loader.sv
// Streams a framed program image (SYNC, LEN, N words, checksum) into the instruction memory.
// The core is held in reset from start until a load completes successfully.
module imem_loader #(
    parameter int                DEPTH  = 16,
    parameter int                ADDR_W = 4,
    parameter int                INST_W = 8,
    parameter logic [INST_W-1:0] SYNC   = 8'hA5
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              in_valid,
    input  logic [INST_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [INST_W-1:0] mem_wdata,
    output logic              core_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // state | meaning
    // IDLE  | waiting for start
    // SYNC  | discarding bytes until the header byte arrives
    // LEN   | next byte is the word count N
    // DATA  | writing N words to imem
    // CSUM  | comparing the trailing byte against the running sum
    // DONE  | one-cycle done pulse, core released on exit
    // ERR   | bad length or checksum, core stays held
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SYNC = 3'd1;
    localparam logic [2:0] S_LEN  = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_CSUM = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;
    localparam logic [2:0] S_ERR  = 3'd6;

    localparam int                CNT_W   = ADDR_W + 1;
    localparam logic [INST_W-1:0] DEPTH_V = INST_W'(DEPTH);

    logic [2:0]        state_q, state_d;
    logic [INST_W-1:0] len_q, len_d;
    logic [CNT_W-1:0]  count_q, count_d, cnt_inc;
    logic [INST_W-1:0] csum_q, csum_d;
    logic              ready_q, ready_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [INST_W-1:0] wdata_q, wdata_d;
    logic              hold_q, hold_d;
    logic              err_q, err_d;
    logic              accept;

    assign accept  = in_valid & ready_q;
    assign cnt_inc = count_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        count_d = count_q;
        csum_d  = csum_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        hold_d  = hold_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SYNC;
                    hold_d  = 1'b1;
                    err_d   = 1'b0;
                    count_d = '0;
                    csum_d  = '0;
                end
            end
            S_SYNC: begin
                if (accept && in_data == SYNC) state_d = S_LEN;
            end
            S_LEN: begin
                if (accept) begin
                    len_d = in_data;
                    if (in_data == '0 || in_data > DEPTH_V) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    we_d    = 1'b1;
                    waddr_d = count_q[ADDR_W-1:0];
                    wdata_d = in_data;
                    csum_d  = csum_q + in_data;
                    count_d = cnt_inc;
                    if (INST_W'(cnt_inc) == len_q) state_d = S_CSUM;
                end
            end
            S_CSUM: begin
                if (accept) begin
                    if (in_data == csum_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                hold_d  = 1'b0;
            end
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // ready is registered, so it follows the state being entered
        ready_d = (state_d == S_SYNC) || (state_d == S_LEN) ||
                  (state_d == S_DATA) || (state_d == S_CSUM);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            count_q <= '0;
            csum_q  <= '0;
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            hold_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            count_q <= count_d;
            csum_q  <= csum_d;
            ready_q <= ready_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            hold_q  <= hold_d;
            err_q   <= err_d;
        end
    end

    assign in_ready  = ready_q;
    assign mem_we    = we_q;
    assign mem_waddr = waddr_q;
    assign mem_wdata = wdata_q;
    assign core_hold = hold_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign err       = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: expected imem writes go into a scoreboard
// queue and are matched against mem_we cycles by a monitor.
module tb_imem_loader;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready, mem_we, core_hold, busy, done, err;
    logic [3:0] mem_waddr;
    logic [7:0] mem_wdata;

    int n_cmp = 0;
    int n_bad = 0;
    logic [11:0] sb[$];
    logic [7:0]  frm[$];

    imem_loader dut (
        .clk(clk), .resetn(resetn), .start(start),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .core_hold(core_hold), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (resetn && mem_we) begin
            if (sb.size() == 0) begin
                chk("unexpected_we", {mem_waddr, mem_wdata}, 0);
            end else begin
                logic [11:0] e;
                e = sb.pop_front();
                chk("waddr", mem_waddr, e[11:8]);
                chk("wdata", mem_wdata, e[7:0]);
            end
        end
    end

    task automatic exp_w(input int a, input logic [7:0] d);
        sb.push_back({4'(a), d});
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Presents one byte and returns 1 time unit after the edge that accepted it.
    task automatic send(input logic [7:0] b, input logic st);
        int   n;
        logic rdy;
        n = 0;
        in_valid = 1'b1;
        in_data  = b;
        start    = st;
        do begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 50);
        if (!rdy) chk("accept_timeout", 0, 1);
        in_valid = 1'b0;
        start    = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic run(input int gap);
        pulse_start();
        foreach (frm[i]) begin
            if (i > 0 && gap > 0) idle(gap);
            send(frm[i], 1'b0);
        end
    endtask

    function automatic logic [31:0] outs();
        return {19'd0, in_ready, mem_we, core_hold, busy, done, err, mem_waddr, mem_wdata};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset then idle
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            idle(1);
            chk("idle_outs", outs(), 0);
        end

        // nominal 4-word load at full rate; start during LEN must be ignored
        exp_w(0, 8'h11); exp_w(1, 8'h22); exp_w(2, 8'h33); exp_w(3, 8'h44);
        pulse_start();
        chk("hold_on_start", core_hold, 1);
        send(8'hA5, 1'b0);
        send(8'h04, 1'b1);
        send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b0);
        send(8'hAA, 1'b0);
        chk("nom_done", done, 1);
        chk("nom_hold_at_done", core_hold, 1);
        chk("nom_err", err, 0);
        chk("nom_sb_empty", sb.size(), 0);
        idle(1);
        chk("nom_done_pulse", done, 0);
        chk("nom_hold_fall", core_hold, 0);
        chk("nom_busy", busy, 0);

        // resync with stalls
        exp_w(0, 8'h80); exp_w(1, 8'h81);
        frm = '{8'h00, 8'hFF, 8'hA5, 8'h02, 8'h80, 8'h81, 8'h01};
        run(2);
        chk("resync_done", done, 1);
        chk("resync_err", err, 0);
        chk("resync_sb_empty", sb.size(), 0);
        idle(1);
        chk("resync_hold", core_hold, 0);

        // checksum error, then a good frame releases the core
        exp_w(0, 8'h5A);
        frm = '{8'hA5, 8'h01, 8'h5A, 8'h00};
        run(0);
        chk("csum_err", err, 1);
        chk("csum_no_done", done, 0);
        idle(1);
        chk("csum_err_sticky", err, 1);
        chk("csum_hold", core_hold, 1);
        chk("csum_idle", busy, 0);
        chk("csum_sb_empty", sb.size(), 0);
        exp_w(0, 8'h07);
        pulse_start();
        chk("err_cleared", err, 0);
        send(8'hA5, 1'b0); send(8'h01, 1'b0); send(8'h07, 1'b0); send(8'h07, 1'b0);
        chk("recover_done", done, 1);
        idle(1);
        chk("recover_hold", core_hold, 0);

        // length zero
        frm = '{8'hA5, 8'h00};
        run(0);
        chk("len0_err", err, 1);
        idle(1);
        chk("len0_hold", core_hold, 1);

        // length above DEPTH
        frm = '{8'hA5, 8'h11};
        run(0);
        chk("len17_err", err, 1);
        idle(3);
        chk("len17_busy", busy, 0);

        // full DEPTH load, checksum 0+1+...+15 = 0x78
        frm = '{8'hA5, 8'h10};
        for (int i = 0; i < 16; i++) begin
            frm.push_back(8'(i));
            exp_w(i, 8'(i));
        end
        frm.push_back(8'h78);
        run(0);
        chk("full_done", done, 1);
        chk("full_err", err, 0);
        chk("full_sb_empty", sb.size(), 0);
        idle(1);
        chk("full_hold", core_hold, 0);

        // async reset in the middle of DATA
        exp_w(0, 8'h11); exp_w(1, 8'h22);
        pulse_start();
        send(8'hA5, 1'b0); send(8'h04, 1'b0); send(8'h11, 1'b0); send(8'h22, 1'b0);
        @(negedge clk);
        #1 resetn = 1'b0;
        #1 chk("rst_outs", outs(), 0);
        idle(3);
        chk("rst_held_outs", outs(), 0);
        resetn = 1'b1;
        idle(5);
        chk("rst_release_outs", outs(), 0);
        chk("rst_sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
